rr_dec_arbiter4: RTL



---
 rtl/rr_dec_arbiter4.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_dec_arbiter4.sv
// Four-requester round-robin arbiter with a decoded one-hot grant.
// Ports: clk, reset (sync, active-high), en, req[3:0], done -> grant[3:0],
//        gnt_idx[1:0], busy, timeout (one-cycle hold-limit release pulse).
module rr_dec_arbiter4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_hold;
    logic [1:0] r_idx;
    logic [3:0] r_grant;
    logic       r_busy;
    logic       r_timeout;

    logic [1:0] w_pick;
    logic [1:0] w_cand;
    logic       w_found;
    logic       w_quit;
    logic       w_hold_hit;
    logic       w_rel;

    // 2-to-4 decoder with enable; the only path from index to grant lines.
    function automatic logic [3:0] dec(input logic e, input logic [1:0] idx);
        logic [3:0] d;
        d = 4'b0000;
        if (e) d[idx] = 1'b1;
        return d;
    endfunction

    // Rotating search: first requester at or after the priority pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_cand  = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Owner-initiated release wins over the hold limit for timeout reporting.
    assign w_quit     = done | ~req[r_idx];
    assign w_hold_hit = (r_hold == HOLD_LAST);
    assign w_rel      = w_quit | w_hold_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_hold    <= 8'd0;
            r_idx     <= 2'd0;
            r_grant   <= 4'b0000;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (en && w_found) begin
                        r_idx   <= w_pick;
                        r_grant <= dec(1'b1, w_pick);
                        r_busy  <= 1'b1;
                        r_hold  <= 8'd0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_rel) begin
                        r_grant   <= 4'b0000;
                        r_busy    <= 1'b0;
                        r_ptr     <= r_idx + 2'd1;
                        r_hold    <= 8'd0;
                        r_timeout <= w_hold_hit & ~w_quit;
                        r_state   <= IDLE;
                    end else if (!w_hold_hit) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant   = r_grant;
    assign gnt_idx = r_idx;
    assign busy    = r_busy;
    assign timeout = r_timeout;

    a_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant));
    a_busy: assert property (@(posedge clk) disable iff (reset)
        busy == (|grant));
    a_dec: assert property (@(posedge clk) disable iff (reset)
        busy |-> (grant == dec(1'b1, gnt_idx)));

endmodule
